key_schedule_seq: RTL
=====================

# key_schedule_seq

Sequential, multi-key-length AES key expansion engine. It accepts a 128/192/256-bit cipher key on a start handshake and generates the expanded key one 32-bit word per clock, reusing a single word-wide S-box. It stores all round keys in an internal register file and serves any round key through an indexed read port. It sits between key loading and the round datapath, and feeds the per-round key XOR stage.

## Interface
- `MAX_NK`, default 8: largest supported key length in words (4, 6 or 8). Sizes the key port and storage; storage holds 4*(MAX_NR+1) words, where MAX_NR = MAX_NK+6.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request expansion; sampled only in IDLE.
- `key_len` in 2: 00=128 (Nk=4, Nr=10), 01=192 (Nk=6, Nr=12), 10=256 (Nk=8, Nr=14); 11 is illegal.
- `key` in 32*MAX_NK: cipher key, MSB-first ([0:...] ordering). Only bits [0:32*Nk-1] are used; the rest are ignored.
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle pulse when the final word is written.
- `err` out 1: one-cycle pulse when a start is rejected.
- `ready` out 1: stored schedule is complete and valid; held until the next accepted start.
- `rk_idx` in 4: round-key index to read.
- `rk` out 128: words 4*rk_idx .. 4*rk_idx+3, combinational from storage.
- `rk_valid` out 1: ready && rk_idx <= Nr of the stored schedule.
- All outputs reset to 0. Storage, word counter and Rcon register reset to 0.

## Operation
- FSM has two states: IDLE and EXPAND.
- IDLE, start=1, legal key_len, Nk <= MAX_NK:
  - latch Nk and Nr;
  - write key words into w[0..Nk-1];
  - set i=Nk and rcon=8'h01;
  - clear ready; set busy; go to EXPAND.
- IDLE, start=1, illegal key_len or Nk > MAX_NK: pulse err; state, storage and ready are unchanged.
- EXPAND, each cycle:
  - temp = w[i-1];
  - if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon), where xtime = shift left 1 and XOR 8'h1b if bit 7 was set;
  - else if Nk == 8 and i mod Nk == 4: temp = SubWord(temp);
  - w[i] = w[i-Nk] ^ temp; i = i+1.
- The i mod Nk test uses a wrapping counter (0..Nk-1) reset on load. No divider.
- When i == 4*(Nr+1)-1 is written: go to IDLE, busy=0, ready=1, done pulses.
- start while busy is ignored (no err). start in the same cycle that done pulses is ignored; it is accepted from the next cycle.
- rk when rk_valid=0 is 128'h0.
- Asynchronous reset mid-expansion aborts the run; all state returns to reset values and a new start is required.

## Timing
- Accepted start edge = edge 0. Word i is written at edge i-Nk+1.
- done, ready rise and busy falls at edge 4*(Nr+1)-Nk: 40 (128-bit), 46 (192-bit), 52 (256-bit).
- A back-to-back start is accepted no earlier than one cycle after done.
- rk is combinational from rk_idx: zero latency.

## Configuration
- `KEYSCHED_ZEROIZE_EN` defined:
  - adds input `zeroize` (1 bit);
  - when high, at the next edge and in any state: all storage words clear to 0, FSM goes to IDLE, busy/ready/done clear;
  - takes priority over start in the same cycle.
- Not defined: the port is absent, and storage retains its contents until overwritten.

## Structure
- Shared package `aes_pkg` holds:
  - key_len encoding constants;
  - Nk/Nr lookup functions;
  - byte S-box function;
  - xtime function;
  - RotWord function.
- Sub-module `aes_sbox_word`: four combinational byte S-boxes, 32 in / 32 out. It is instantiated once and shared by both SubWord cases.

## Test plan
- 128-bit key 2b7e151628aed2a6abf7158809cf4f3c: done at edge 40; rk_idx=10 gives rk=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_valid=1; rk_idx=11 gives rk_valid=0, rk=0.
- 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: done at edge 46; rk_idx=12, last word = 01002202.
- 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: done at edge 52; rk_idx=14, last word = 706c631e.
- key_len=11, and key_len=10 with MAX_NK=4: err pulses for one cycle; busy stays 0; prior ready and schedule are unchanged.
- rst_n low at edge 20 of a 128-bit run: all outputs go to 0 immediately. A restart afterwards completes at edge 40 with correct keys. A start pulsed while busy has no effect on done timing.
- `KEYSCHED_ZEROIZE_EN`: zeroize after ready gives ready=0 and rk=0 for all indices. zeroize together with start leaves the FSM in IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: AES constants and byte-level helpers shared by the key schedule.
// Holds the key_len encodings, the Nk/Nr lookups, the S-box, xtime and RotWord.
package aes_pkg;
  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_BAD = 2'b11;
  // Forward S-box, byte 0x00 in the leftmost position
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Illegal encodings map to 0 so callers can reject them
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    return kl == KL_128 ? 4'd4 : kl == KL_192 ? 4'd6 : kl == KL_256 ? 4'd8 : 4'd0;
  endfunction
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return kl == KL_128 ? 4'd10 : kl == KL_192 ? 4'd12 : kl == KL_256 ? 4'd14 : 4'd0;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_sbox_word.sv
// aes_sbox_word: SubWord, four parallel byte S-boxes on one 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
endmodule

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: one-word-per-clock AES-128/192/256 key expansion with an indexed round-key read port.
// Optional KEYSCHED_ZEROIZE_EN adds a zeroize input that wipes storage and returns to IDLE.
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic                 zeroize,
`endif
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [0:32*MAX_NK-1] key,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ready,
  input  logic [3:0]           rk_idx,
  output logic [127:0]         rk,
  output logic                 rk_valid
);
  localparam int NW = 4 * (MAX_NK + 7);
  localparam int IW = $clog2(NW);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;
  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);
  logic [0:0] state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [3:0] mod_q, mod_d, nk_q, nk_d, nr_q, nr_d;
  logic [7:0] rcon_q, rcon_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];
  logic zap, take, legal, last;
  logic [3:0] nk_in;
  logic [31:0] prev, sub_in, sub_out, temp, new_word;
  logic [IW-1:0] base;
`ifdef KEYSCHED_ZEROIZE_EN
  assign zap = zeroize;
`else
  assign zap = 1'b0;
`endif
  assign nk_in = nk_of(key_len);
  assign legal = key_len != KL_BAD && nk_in <= MAX_NK_W;
  // The cycle done is high still counts as busy for start acceptance
  assign take = state_q == IDLE && start && !done_q && !zap;
  assign prev = w_q[i_q - IW'(1)];
  assign sub_in = mod_q == 4'd0 ? rot_word(prev) : prev;
  aes_sbox_word u_sbox (.a(sub_in), .y(sub_out));
  assign temp = mod_q == 4'd0 ? sub_out ^ {rcon_q, 24'h0} :
                (nk_q == 4'd8 && mod_q == 4'd4) ? sub_out : prev;
  assign new_word = w_q[i_q - IW'(nk_q)] ^ temp;
  assign last = i_q == IW'({nr_q, 2'b11});
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    mod_d = mod_q;
    nk_d = nk_q;
    nr_d = nr_q;
    rcon_d = rcon_q;
    busy_d = busy_q;
    ready_d = ready_q;
    done_d = 1'b0;
    err_d = 1'b0;
    w_d = w_q;
    if (zap) begin
      state_d = IDLE;
      busy_d = 1'b0;
      ready_d = 1'b0;
      w_d = '{default: '0};
    end else if (state_q == IDLE) begin
      if (take && legal) begin
        for (int j = 0; j < MAX_NK; j++)
          if (4'(j) < nk_in) w_d[j] = key[32*j +: 32];
        nk_d = nk_in;
        nr_d = nr_of(key_len);
        i_d = IW'(nk_in);
        mod_d = 4'd0;
        rcon_d = 8'h01;
        ready_d = 1'b0;
        busy_d = 1'b1;
        state_d = EXPAND;
      end else if (take) begin
        err_d = 1'b1;
      end
    end else begin
      w_d[i_q] = new_word;
      i_d = i_q + IW'(1);
      mod_d = mod_q == nk_q - 4'd1 ? 4'd0 : mod_q + 4'd1;
      rcon_d = mod_q == 4'd0 ? xtime(rcon_q) : rcon_q;
      if (last) begin
        state_d = IDLE;
        busy_d = 1'b0;
        ready_d = 1'b1;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q <= '0;
      mod_q <= '0;
      nk_q <= '0;
      nr_q <= '0;
      rcon_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ready_q <= 1'b0;
      w_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      mod_q <= mod_d;
      nk_q <= nk_d;
      nr_q <= nr_d;
      rcon_q <= rcon_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      ready_q <= ready_d;
      w_q <= w_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign ready = ready_q;
  assign rk_valid = ready_q && rk_idx <= nr_q;
  // Clamp the base so an out-of-range index never addresses past storage
  assign base = rk_valid ? IW'({rk_idx, 2'b00}) : '0;
  assign rk = rk_valid ? {w_q[base], w_q[base + IW'(1)], w_q[base + IW'(2)], w_q[base + IW'(3)]} : 128'h0;
endmodule
